// File: rtl/serial_subtractor_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding and
// the bit-counter width helper.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Counter counts WIDTH-1 down to 0; never narrower than one bit.
  function automatic int cnt_w(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full-subtractor cell: diff = a - b - b_in, with borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic b_in,
  output logic diff,
  output logic b_out
);

  assign diff  = a ^ b ^ b_in;
  assign b_out = (~a & b) | (~(a ^ b) & b_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, behind a start/ready/done handshake.
// Results and flags are committed together on the last shift.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int CW = cnt_w(WIDTH);

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, diff_q;
  logic [WIDTH-2:0] res_q;
  logic [CW-1:0]    cnt_q;
  logic             bor_q, amsb_q, bmsb_q;
  logic             ready_q, done_q, borrow_q, ovf_q;

  logic             d_bit, bout;
  logic [WIDTH-1:0] res_d;

  full_subtractor u_fs (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .b_in (bor_q),
    .diff (d_bit),
    .b_out(bout)
  );

  // Partial result plus the bit being produced this cycle; on the last
  // shift this is the complete difference.
  assign res_d = {d_bit, res_q};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      bor_q    <= 1'b0;
      amsb_q   <= 1'b0;
      bmsb_q   <= 1'b0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            amsb_q  <= a[WIDTH-1];
            bmsb_q  <= b[WIDTH-1];
            bor_q   <= 1'b0;
            cnt_q   <= CW'(WIDTH - 1);
            ready_q <= 1'b0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          res_q <= res_d[WIDTH-1:1];
          bor_q <= bout;
          if (cnt_q == '0) begin
            diff_q   <= res_d;
            borrow_q <= bout;
            // Signed overflow: operand signs differ and result sign != minuend sign.
            ovf_q    <= (amsb_q ^ bmsb_q) & (d_bit ^ amsb_q);
            done_q   <= 1'b1;
            state_q  <= DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ready      = ready_q;
  assign done       = done_q;
  assign diff       = diff_q;
  assign borrow_out = borrow_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor at WIDTH 8, 2 and 16: per-cycle comparison
// against a timestamp-based model, plus directed literal checks.
module tb_serial_subtractor;

  localparam int NL = 3;
  localparam int WS [NL] = '{8, 2, 16};

  logic        clk;
  logic        reset;
  logic        st  [NL];
  logic [31:0] av  [NL];
  logic [31:0] bv  [NL];
  logic [31:0] dv  [NL];
  logic        rdy [NL];
  logic        dn  [NL];
  logic        bo  [NL];
  logic        ov  [NL];

  int total = 0;
  int bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic ovf_of(input int w, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, r;
    sx = longint'(x);
    sy = longint'(y);
    if (x[w-1]) sx -= (longint'(1) << w);
    if (y[w-1]) sy -= (longint'(1) << w);
    r = sx - sy;
    return (r > ((longint'(1) << (w - 1)) - 1)) || (r < -(longint'(1) << (w - 1)));
  endfunction

  for (genvar g = 0; g < NL; g++) begin : L
    localparam int W = WS[g];
    localparam logic [31:0] MASK = 32'((64'd1 << W) - 64'd1);

    logic [W-1:0] d_w;

    serial_subtractor #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (st[g]),
      .a         (av[g][W-1:0]),
      .b         (bv[g][W-1:0]),
      .ready     (rdy[g]),
      .done      (dn[g]),
      .diff      (d_w),
      .borrow_out(bo[g]),
      .overflow  (ov[g])
    );
    assign dv[g] = 32'(d_w);

    // Model: remember the edge number at which an operation was accepted;
    // results appear W edges later, idle again one edge after that.
    longint      e     = 0;
    longint      acc   = -1;
    logic        m_rdy = 1'b1;
    logic        m_dn  = 1'b0;
    logic        m_bo  = 1'b0;
    logic        m_ov  = 1'b0;
    logic [31:0] m_d   = '0;
    logic [31:0] ca    = '0;
    logic [31:0] cb    = '0;

    always @(posedge clk or posedge reset) begin
      if (reset) begin
        acc   <= -1;
        m_rdy <= 1'b1;
        m_dn  <= 1'b0;
        m_d   <= '0;
        m_bo  <= 1'b0;
        m_ov  <= 1'b0;
      end else begin
        e <= e + 1;
        if (acc < 0) begin
          if (st[g]) begin
            acc   <= e + 1;
            m_rdy <= 1'b0;
            ca    <= av[g] & MASK;
            cb    <= bv[g] & MASK;
          end
        end else if (e + 1 == acc + W) begin
          m_dn <= 1'b1;
          m_d  <= (ca - cb) & MASK;
          m_bo <= (ca < cb);
          m_ov <= ovf_of(W, ca, cb);
        end else if (e + 1 == acc + W + 1) begin
          m_dn  <= 1'b0;
          m_rdy <= 1'b1;
          acc   <= -1;
        end
      end
    end

    always @(negedge clk) begin
      chk($sformatf("L%0d ready", g),  32'(rdy[g]), 32'(m_rdy));
      chk($sformatf("L%0d done", g),   32'(dn[g]),  32'(m_dn));
      chk($sformatf("L%0d diff", g),   dv[g],       m_d);
      chk($sformatf("L%0d borrow", g), 32'(bo[g]),  32'(m_bo));
      chk($sformatf("L%0d ovf", g),    32'(ov[g]),  32'(m_ov));
    end
  end

  task automatic wait_ready(input int l);
    int guard = 0;
    @(negedge clk);
    while (!rdy[l] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
  endtask

  task automatic run_op(input int l, input logic [31:0] x, input logic [31:0] y, output int lat);
    wait_ready(l);
    st[l] = 1'b1; av[l] = x; bv[l] = y;
    @(posedge clk); #1;
    st[l] = 1'b0; av[l] = $urandom; bv[l] = $urandom;
    lat = 0;
    while (lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (dn[l]) break;
    end
  endtask

  task automatic op8(input string nm, input logic [7:0] x, input logic [7:0] y,
                     input logic [7:0] ed, input logic eb, input logic eo);
    int lat;
    run_op(0, 32'(x), 32'(y), lat);
    chk({nm, " latency"}, 32'(lat), 32'd8);
    chk({nm, " diff"},    dv[0],    32'(ed));
    chk({nm, " borrow"},  32'(bo[0]), 32'(eb));
    chk({nm, " ovf"},     32'(ov[0]), 32'(eo));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, cnt, t, t1, t2;
    reset = 1'b0;
    for (int i = 0; i < NL; i++) begin
      st[i] = 1'b0; av[i] = '0; bv[i] = '0;
    end
    #1 reset = 1'b1;
    #1;
    chk("reset ready",  32'(rdy[0]), 32'd1);
    chk("reset done",   32'(dn[0]),  32'd0);
    chk("reset diff",   dv[0],       32'd0);
    chk("reset borrow", 32'(bo[0]),  32'd0);
    chk("reset ovf",    32'(ov[0]),  32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    op8("5A-3C", 8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0);
    op8("00-01", 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
    op8("80-01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    op8("7F-FF", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);

    // Second start during SHIFT must be ignored.
    wait_ready(0);
    st[0] = 1'b1; av[0] = 32'h33; bv[0] = 32'h11;
    @(posedge clk); #1 st[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1 st[0] = 1'b1; av[0] = 32'hF0; bv[0] = 32'h0F;
    @(posedge clk); #1 st[0] = 1'b0;
    t = 0;
    while (!dn[0] && t < 20) begin @(posedge clk); #1; t++; end
    chk("ignored start done", 32'(dn[0]), 32'd1);
    chk("ignored start diff", dv[0], 32'h22);
    cnt = 0;
    repeat (12) begin @(posedge clk); #1; if (dn[0]) cnt++; end
    chk("ignored start extra", 32'(cnt), 32'd0);

    // Start held high: one operation every WIDTH+2 cycles.
    wait_ready(0);
    st[0] = 1'b1; av[0] = 32'h09; bv[0] = 32'h03;
    cnt = 0; t1 = -1; t2 = -1;
    for (int c = 1; c <= 35; c++) begin
      @(posedge clk); #1;
      if (dn[0]) begin
        cnt++;
        if (t1 < 0) t1 = c; else if (t2 < 0) t2 = c;
      end
    end
    st[0] = 1'b0;
    chk("held count",    32'(cnt),     32'd3);
    chk("held first",    32'(t1),      32'd9);
    chk("held interval", 32'(t2 - t1), 32'd10);
    chk("held diff",     dv[0],        32'h06);

    // Reset in the middle of SHIFT aborts the operation.
    wait_ready(0);
    st[0] = 1'b1; av[0] = 32'h44; bv[0] = 32'h11;
    @(posedge clk); #1 st[0] = 1'b0;
    repeat (4) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midreset ready",  32'(rdy[0]), 32'd1);
    chk("midreset done",   32'(dn[0]),  32'd0);
    chk("midreset diff",   dv[0],       32'd0);
    chk("midreset borrow", 32'(bo[0]),  32'd0);
    @(posedge clk); #1 reset = 1'b0;
    cnt = 0;
    repeat (12) begin @(posedge clk); #1; if (dn[0]) cnt++; end
    chk("midreset no done", 32'(cnt), 32'd0);
    op8("10-10", 8'h10, 8'h10, 8'h00, 1'b0, 1'b0);

    // Width sweeps: exhaustive at 2 bits, random at 16 bits.
    fork
      begin
        int l2;
        for (int x = 0; x < 4; x++)
          for (int y = 0; y < 4; y++) begin
            run_op(1, 32'(x), 32'(y), l2);
            chk("w2 latency", 32'(l2), 32'd2);
          end
      end
      begin
        int l16;
        run_op(2, 32'h8000, 32'h0001, l16);
        chk("w16 latency", 32'(l16), 32'd16);
        chk("w16 8000-0001 diff", dv[2], 32'h7FFF);
        chk("w16 8000-0001 ovf",  32'(ov[2]), 32'd1);
        for (int i = 0; i < 25; i++) begin
          run_op(2, $urandom, $urandom, l16);
          chk("w16 latency", 32'(l16), 32'd16);
        end
      end
    join

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

- Bit-serial N-bit subtractor: computes diff = a − b one bit per clock, LSB first, using a single one-bit full-subtractor cell and a borrow flip-flop.
- Arithmetic counterpart of the combinational full-adder datapath. Used where area matters more than latency.
- Sits behind a start/ready/done handshake so a controller can issue operations and collect the difference, unsigned borrow and signed overflow flags.

## Interface
- Clock: one clock, `clk`.
- Reset: `reset`, asynchronous and active-high.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only while ready=1
- a  input  WIDTH  minuend, captured on accepted start
- b  input  WIDTH  subtrahend, captured on accepted start
- ready  output  1  block idle, start will be accepted
- done  output  1  one-cycle pulse, results valid
- diff  output  WIDTH  a − b modulo 2^WIDTH
- borrow_out  output  1  1 when a < b, unsigned
- overflow  output  1  signed two's-complement overflow of a − b

## Operation
- FSM states:
  - IDLE: ready=1. start=1 → capture a, b into shift registers, clear the borrow FF, load the bit counter with WIDTH−1, go to SHIFT.
  - SHIFT: each cycle, the cell computes d = a0 ^ b0 ^ bin and bout = (~a0 & b0) | (~(a0 ^ b0) & bin).
    - d shifts into the MSB of the result register; a/b registers shift right; the borrow FF takes bout.
    - Counter = 0 → go to DONE; otherwise decrement.
  - DONE: done=1 for exactly this cycle; go unconditionally to IDLE.
- Result commit: diff, borrow_out and overflow are registered outputs, all updated on the transition SHIFT→DONE.
  - borrow_out = final bout.
  - overflow = (a[MSB] ≠ b[MSB]) & (diff[MSB] ≠ a[MSB]), using the captured operand MSBs.
  - Outputs hold until the next commit; they do not change on start acceptance.
- start while ready=0 (SHIFT or DONE) is ignored; no queueing.
- Inputs a and b are don't-care except in the cycle where start is accepted.

## Timing
- Reset (asynchronous, immediate): state=IDLE, ready=1, done=0, diff=0, borrow_out=0, overflow=0, counter=0, borrow FF=0.
- Start accepted at rising edge k:
  - SHIFT occupies cycles k+1..k+WIDTH.
  - done=1 and results valid in cycle k+WIDTH (after edge k+WIDTH).
  - ready=1 again after edge k+WIDTH+1.
- Latency: start edge to done = WIDTH cycles. Issue interval = WIDTH+2 cycles minimum (back-to-back starts).
- ready is low throughout SHIFT and DONE.
- Reset asserted mid-SHIFT: operation aborted, no done pulse. Outputs return to reset values; the previous results are not preserved.
- Reset released: first start is accepted at the first rising edge with reset low.
- Wrap-around: the counter never underflows; the transition is taken at counter=0.

## Structure
- Package serial_sub_pkg:
  - state enum (IDLE, SHIFT, DONE), 2-bit encoded.
  - CNT_W = $clog2(WIDTH) helper function.
- Sub-module full_subtractor:
  - inputs a, b, b_in; outputs diff, b_out.
  - Purely combinational, instantiated once.
- Top level: FSM, counter, operand/result shift registers, borrow FF, flag logic.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C → done after 8 cycles; diff=0x1E, borrow_out=0, overflow=0.
- a=0x00, b=0x01 → diff=0xFF, borrow_out=1, overflow=0.
- a=0x80, b=0x01 → diff=0x7F, borrow_out=0, overflow=1. Then a=0x7F, b=0xFF → diff=0x80, borrow_out=1, overflow=1.
- Handshake:
  - start held high continuously → one operation per 10 cycles, done pulses exactly 1 cycle wide.
  - A second start pulse with different operands during SHIFT is ignored; results match the first operands.
- Reset mid-operation: assert reset at SHIFT cycle 4 → ready=1, diff=0, no done pulse. A subsequent a=0x10, b=0x10 gives diff=0x00, borrow_out=0, overflow=0.
- Randomised sweep at WIDTH=2 and WIDTH=16 against a reference model of a−b, borrow (a<b) and signed overflow; check done-to-start latency = WIDTH.
